// File: rtl/stream_playback.sv
// Frame-store stream source: one frame is loaded over s_* and replayed on m_* per start pulse.
// Optional macro STREAM_PLAYBACK_REPEAT_EN honours repeat_count (extra passes per start).
module stream_playback #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned REPEAT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_last,
    input  logic                    start,
    input  logic [REPEAT_WIDTH-1:0] repeat_count,
    output logic                    busy,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  length,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [LW-1:0]    length_q, length_d;
    logic             overflow_q, overflow_d, issued_q, issued_d;
    logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic             s_ready_q, busy_q;
    logic [WIDTH-1:0] m_data_q;
    logic             s_fire_c, m_fire_c, start_ok_c, issue_c, at_end_c, last_pass_c, wr_full_c;
    logic [AW-1:0]    last_addr_c, wr_addr_c;

    assign s_fire_c    = s_valid & s_ready_q;
    assign m_fire_c    = m_valid_q & m_ready;
    assign start_ok_c  = (state_q == IDLE) & start & ~s_fire_c & (length_q != '0);
    // A new sample is fetched whenever the output register is empty or draining.
    assign issue_c     = (state_q == PLAY) & ~issued_q & (~m_valid_q | m_ready);
    assign last_addr_c = AW'(length_q - LW'(1));
    assign at_end_c    = (r_addr_q == last_addr_c);
    assign wr_full_c   = (w_addr_q == AW'(DEPTH - 1));
    assign wr_addr_c   = (state_q == LOAD) ? w_addr_q : '0;

`ifdef STREAM_PLAYBACK_REPEAT_EN
    logic [REPEAT_WIDTH-1:0] reps_q, reps_d;

    assign last_pass_c = (reps_q == '0);

    always_comb begin
        reps_d = reps_q;
        if (start_ok_c) begin
            reps_d = repeat_count;
        end else if (issue_c && at_end_c && !last_pass_c) begin
            reps_d = reps_q - REPEAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reps_q <= '0;
        end else begin
            reps_q <= reps_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^repeat_count;
    assign last_pass_c   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s_fire_c) begin
                    if (!s_last) state_d = LOAD;
                end else if (start_ok_c) begin
                    state_d = PLAY;
                end
            end
            LOAD: if (s_fire_c && (s_last || wr_full_c)) state_d = IDLE;
            PLAY: if (m_fire_c && m_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_addr_d   = w_addr_q;
        length_d   = length_q;
        overflow_d = overflow_q;
        r_addr_d   = r_addr_q;
        issued_d   = issued_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        if (s_fire_c) begin
            if (state_q == IDLE) begin
                overflow_d = 1'b0;
                length_d   = s_last ? LW'(1) : '0;
                w_addr_d   = AW'(1);
            end else if (s_last) begin
                length_d = LW'(w_addr_q) + LW'(1);
            end else if (wr_full_c) begin
                length_d   = LW'(DEPTH);
                overflow_d = 1'b1;
            end else begin
                w_addr_d = w_addr_q + AW'(1);
            end
        end
        if (start_ok_c) begin
            r_addr_d = '0;
            issued_d = 1'b0;
        end
        if (issue_c) begin
            m_valid_d = 1'b1;
            m_last_d  = at_end_c & last_pass_c;
            if (at_end_c) begin
                r_addr_d = '0;
                issued_d = last_pass_c;
            end else begin
                r_addr_d = r_addr_q + AW'(1);
            end
        end else if (m_fire_c) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_addr_q   <= '0;
            length_q   <= '0;
            overflow_q <= 1'b0;
            r_addr_q   <= '0;
            issued_q   <= 1'b1;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            s_ready_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            w_addr_q   <= w_addr_d;
            length_q   <= length_d;
            overflow_q <= overflow_d;
            r_addr_q   <= r_addr_d;
            issued_q   <= issued_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            s_ready_q  <= (state_d != PLAY);
            busy_q     <= (state_d != IDLE) | m_valid_d;
        end
    end

    // Frame RAM with synchronous read straight into the output register.
    always_ff @(posedge clk) begin
        if (s_fire_c) mem[wr_addr_c] <= s_data;
        if (issue_c)  m_data_q <= mem[r_addr_q];
    end

    assign s_ready  = s_ready_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign length   = length_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
endmodule

// File: tb/tb_stream_playback.sv
// Directed bench for stream_playback (DEPTH=8) with an expected-beat scoreboard queue.
module tb_stream_playback;
    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, s_valid, s_ready, s_last, start, busy, overflow;
    logic [15:0] s_data, m_data;
    logic [3:0]  repeat_count, length;
    logic        m_valid, m_ready, m_last;

    int          checks = 0;
    int          errors = 0;
    beat_t       q[$];
    logic [15:0] frm[8];
    int          flen = 0;
    int          n;

    stream_playback #(.WIDTH(16), .DEPTH(8), .REPEAT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .start(start), .repeat_count(repeat_count), .busy(busy),
        .overflow(overflow), .length(length), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score any output beat at negedge, then advance to just after posedge.
    task automatic cyc();
        @(negedge clk);
        if (m_valid === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat: observed data %0h expected no beat", m_data);
            end
            if (q.size() != 0) begin
                chk("beat_data", 32'(m_data), 32'(q[0].d));
                chk("beat_last", 32'(m_last), 32'(q[0].l));
                if (m_ready) void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [15:0] base, input int cnt);
        flen = cnt;
        for (int i = 0; i < cnt; i++) begin
            frm[i]  = base + 16'(i);
            s_valid = 1'b1;
            s_data  = frm[i];
            s_last  = (i == cnt - 1);
            cyc();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_frame(input int passes);
        beat_t b;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < flen; i++) begin
                b.d = frm[i];
                b.l = (p == passes - 1) && (i == flen - 1);
                q.push_back(b);
            end
        end
    endtask

    task automatic play(input int rep);
        int passes;
        int cnt;
        passes = 1;
`ifdef STREAM_PLAYBACK_REPEAT_EN
        passes = rep + 1;
`endif
        push_frame(passes);
        repeat_count = 4'(rep);
        m_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("latency_n1_valid", 32'(m_valid), 32'd0);
        chk("play_busy", 32'(busy), 32'd1);
        cyc();
        chk("latency_n2_valid", 32'(m_valid), 32'd1);
        cnt = 0;
        while (q.size() != 0 && cnt < 100) begin
            cyc();
            cnt++;
        end
        chk("b2b_cycles", 32'(cnt), 32'(passes * flen));
        chk("end_valid", 32'(m_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        start = 1'b0; repeat_count = '0; m_ready = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_length", 32'(length), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);

        // start on an empty store is ignored
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        chk("empty_start_valid", 32'(m_valid), 32'd0);
        chk("empty_start_busy", 32'(busy), 32'd0);

        load_frame(16'hA0, 4);
        chk("load4_length", 32'(length), 32'd4);
        chk("load4_overflow", 32'(overflow), 32'd0);
        chk("load4_busy", 32'(busy), 32'd0);
        play(0);
        play(2);

        // stalls with m_ready 1,0,0,1 and a start issued mid-playback
        push_frame(1);
        repeat_count = '0;
        m_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            m_ready = (n % 4 == 0) || (n % 4 == 3);
            start = (n == 2);
            cyc();
            n++;
            if (n == 3) chk("play_s_ready", 32'(s_ready), 32'd0);
        end
        start = 1'b0;
        m_ready = 1'b1;
        chk("stall_drained", 32'(q.size()), 32'd0);
        repeat (3) cyc();
        chk("stall_end_valid", 32'(m_valid), 32'd0);
        chk("stall_end_busy", 32'(busy), 32'd0);

        // overflow at DEPTH, start during LOAD and start colliding with a new load
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 16'hB0 + 16'(i);
            s_last = (i == 9);
            start  = (i == 2) || (i == 8);
            cyc();
            if (i == 7) begin
                chk("ovf_length", 32'(length), 32'd8);
                chk("ovf_flag", 32'(overflow), 32'd1);
            end
            if (i == 8) begin
                chk("reload_ovf_clr", 32'(overflow), 32'd0);
                chk("reload_length", 32'(length), 32'd0);
                chk("reload_s_ready", 32'(s_ready), 32'd1);
                chk("reload_valid", 32'(m_valid), 32'd0);
            end
        end
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        chk("reload2_length", 32'(length), 32'd2);
        chk("reload2_busy", 32'(busy), 32'd0);
        frm[0] = 16'hB8; frm[1] = 16'hB9; flen = 2;
        play(1);

        load_frame(16'hC5, 1);
        chk("len1_length", 32'(length), 32'd1);
        play(2);

        // reset during the third playback beat
        load_frame(16'hA0, 4);
        push_frame(1);
        repeat_count = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        chk("pre_reset_valid", 32'(m_valid), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        q.delete();
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_length", 32'(length), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        chk("post_rst_start_valid", 32'(m_valid), 32'd0);
        chk("post_rst_start_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_playback.md
Name: stream_playback

Overview:
Memory-backed stream source that is the read-out counterpart of the team's valid/ready FIFO storage. An upstream producer loads one frame of samples into internal RAM. On a `start` pulse, the block replays that frame on a valid/ready master stream, optionally repeated. Intended for preamble/training-sequence and test-vector sourcing in the PHY transmit path.

Parameters:
- WIDTH, 32, sample width in bits.
- DEPTH, 1024, frame storage in samples; power of two, minimum 2.
- REPEAT_WIDTH, 8, width of the repeat count input.

Ports:
- clk  input  1  clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  load-stream valid.
- s_ready  output  1  load-stream ready.
- s_data  input  WIDTH  load-stream sample.
- s_last  input  1  marks final sample of the frame being loaded.
- start  input  1  single-cycle playback request.
- repeat_count  input  REPEAT_WIDTH  extra repetitions after the first pass; sampled with start.
- busy  output  1  high while in LOAD or PLAY.
- overflow  output  1  sticky; set when a load is truncated at DEPTH.
- length  output  $clog2(DEPTH)+1  number of samples in the stored frame; 0 means empty.
- m_valid  output  1  playback-stream valid.
- m_ready  input  1  playback-stream ready.
- m_data  output  WIDTH  playback-stream sample.
- m_last  output  1  high on the final sample of the final repetition.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Names are clk and reset.
- Reset values: s_ready=1, busy=0, overflow=0, length=0, m_valid=0, m_last=0. m_data is don't-care.
- States are IDLE, LOAD and PLAY. Reset enters IDLE. Reset asserted mid-LOAD or mid-PLAY forces IDLE and clears length; m_valid is 0 the cycle after reset.

IDLE:
- s_ready=1.
- First accepted s beat: write address 0, length←0, overflow←0.
  - If s_last is high on that beat, go to IDLE with length=1.
  - Otherwise go to LOAD.
- start with length≠0: go to PLAY, r_addr←0, reps←repeat_count.
- start with length=0 is ignored.
- If s_valid and start are both high, the load wins and start is ignored.

LOAD:
- s_ready=1; start is ignored.
- Each accepted beat writes the next address.
- Accepted beat with s_last: length←count of beats written; go to IDLE.
- Beat written to address DEPTH-1 without s_last: terminate the load, length←DEPTH, overflow←1, go to IDLE. Remaining upstream beats are treated as a new load.

PLAY:
- s_ready=0; start is ignored.
- RAM read address is registered, followed by an output register; data is read synchronously.
- Latency: start sampled in cycle N, first m_valid in cycle N+2.
- With m_ready held high: one sample per cycle, no bubbles, including across repetition boundaries (address wraps from length-1 to 0).
- Stall (m_valid & ~m_ready): m_data, m_last and m_valid are held stable.
- Playback ends after the beat with m_last is accepted: go to IDLE, m_valid=0 next cycle unless a new start follows.
- The stored frame and length persist, so start may replay the frame any number of times.

Other rules:
- busy = (state≠IDLE) | m_valid.
- length=1 frame: each repetition is one beat at address 0.

Optional Feature:
- Macro: STREAM_PLAYBACK_REPEAT_EN.
- Defined: repeat_count is honoured. Total passes = repeat_count+1, and m_last is high only on the last beat of the last pass.
- Undefined: repeat_count is ignored and the reps counter is not built. Every start plays exactly one pass; m_last is high on beat length-1.

Test Plan:
- Load 4 beats 0xA0..0xA3, s_last on 0xA3, then start with repeat_count=0 and m_ready=1 -> length=4; m_valid first at start+2; m_data A0,A1,A2,A3 on consecutive cycles; m_last only with A3; busy drops afterwards.
- Same frame, start with repeat_count=2 (REPEAT_EN defined) -> 12 back-to-back beats A0..A3 ×3; m_last only on the 12th beat. With the macro undefined -> 4 beats.
- m_ready toggled 1,0,0,1 during playback -> no beat dropped or duplicated; m_data/m_last stable while stalled.
- DEPTH=8: stream 10 beats with no s_last -> length=8, overflow=1 after beat 8; beats 9–10 start a new load (length=2 on s_last); overflow is cleared by that new load.
- start with length=0, and start issued during LOAD or PLAY -> ignored; no m_valid, state unchanged.
- reset asserted on the 3rd beat of playback -> m_valid=0, length=0 and s_ready=1 the next cycle; a subsequent start is ignored.
